seg7_scan_capture: RTL and testbench

//  Receive-side monitor for the multiplexed seven-segment display bus. Samples the

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_scan_capture_if.sv | 21 ++
 rtl/seg7_pattern_decoder.sv | 28 ++
 rtl/seg7_scan_capture.sv | 138 +++++++++++++
 tb/tb_seg7_scan_capture.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan capture monitor.
// Segment patterns use {g,f,e,d,c,b,a} bit order, active high.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] DIGIT_BLANK   = 4'hF;
    localparam logic [3:0] DIGIT_INVALID = 4'hE;

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic       err;
        logic [3:0] digit;
    } decode_t;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Display-bus tap: raw segment/select lines in, captured frame and status out.
interface seg7_scan_capture_if #(
    parameter int NUM_DIGITS = 6
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   dig_sel_in;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic [NUM_DIGITS-1:0]   digit_err_out;
    logic                    frame_valid_out;
    logic                    scan_err_out;

    modport master (
        output seg_in, dig_sel_in,
        input  digits_out, digit_err_out, frame_valid_out, scan_err_out
    );

    modport slave (
        input  seg_in, dig_sel_in,
        output digits_out, digit_err_out, frame_valid_out, scan_err_out
    );
endinterface

// File: rtl/seg7_pattern_decoder.sv
// Maps a segment pattern back to its BCD digit; the inverse of the display encoder.
module seg7_pattern_decoder
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output decode_t    dec
);

    always_comb begin
        // NOTE: default assignment first keeps this always_comb latch-free
        dec = '{err: 1'b0, digit: DIGIT_INVALID};
        case (seg)
            SEG_0:     dec.digit = 4'd0;
            SEG_1:     dec.digit = 4'd1;
            SEG_2:     dec.digit = 4'd2;
            SEG_3:     dec.digit = 4'd3;
            SEG_4:     dec.digit = 4'd4;
            SEG_5:     dec.digit = 4'd5;
            SEG_6:     dec.digit = 4'd6;
            SEG_7:     dec.digit = 4'd7;
            SEG_8:     dec.digit = 4'd8;
            SEG_9:     dec.digit = 4'd9;
            SEG_BLANK: dec.digit = DIGIT_BLANK;
            default:   dec.err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive-side monitor for the multiplexed 7-segment bus: captures each stable
// digit dwell and publishes complete, coherent frames of decoded digits.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_capture_if.slave bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    logic [6:0]            seg_s1, seg_s2, seg_q;
    logic [NUM_DIGITS-1:0] sel_s1, sel_s2, sel_q;
    logic [CNT_W-1:0]      cnt;
    logic [TO_W-1:0]       to_cnt;
    scan_state_e           state;
    logic [NUM_DIGITS-1:0] seen;
    logic [3:0]            shadow_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] shadow_err;
    logic [4*NUM_DIGITS-1:0] digits_r;
    logic [NUM_DIGITS-1:0] digit_err_r;
    logic                  frame_valid_r;
    logic                  scan_err_r;
    decode_t               dec;

    logic changed, stable, sel_onehot, sel_multi;
    logic evaluate, capture, multi_err, timeout, frame_done;

    // seg_q/sel_q hold the previous sample; every sample in a stable run equals it.
    assign changed    = (seg_s2 != seg_q) || (sel_s2 != sel_q);
    assign stable     = (cnt == CNT_W'(STABLE_CYCLES - 1));
    assign sel_onehot = $onehot(sel_q);
    assign sel_multi  = (sel_q != '0) && !sel_onehot;
    assign evaluate   = (state == SETTLE) && stable;
    assign capture    = evaluate && sel_onehot;
    assign multi_err  = evaluate && sel_multi;
    assign timeout    = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !capture;
    assign frame_done = &seen;

    seg7_pattern_decoder u_decoder (
        .seg (seg_q),
        .dec (dec)
    );

    // Synchronisers, previous-sample register and saturating stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            seg_q  <= '0;
            sel_s1 <= '0;
            sel_s2 <= '0;
            sel_q  <= '0;
            cnt    <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values
            seg_s1 <= bus.seg_in;
            seg_s2 <= seg_s1;
            seg_q  <= seg_s2;
            sel_s1 <= bus.dig_sel_in;
            sel_s2 <= sel_s1;
            sel_q  <= sel_s2;
            if (changed)
                cnt <= '0;
            else if (!stable)
                cnt <= cnt + 1'b1;
        end
    end

    // Dwell FSM; a change seen on the evaluation cycle starts the next dwell directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SETTLE;
            scan_err_r <= 1'b0;
        end else begin
            scan_err_r <= multi_err || timeout;
            case (state)
                SETTLE: if (stable && !changed) state <= HOLD;
                HOLD:   if (changed)            state <= SETTLE;
                default:                        state <= SETTLE;
            endcase
        end
    end

    // Seen mask, shadows, published frame and inter-capture timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen          <= '0;
            shadow_err    <= '0;
            to_cnt        <= '0;
            digits_r      <= {NUM_DIGITS{DIGIT_BLANK}};
            digit_err_r   <= '0;
            frame_valid_r <= 1'b0;
            // NOTE: the shadow array is small and is reset so a discarded frame leaves nothing behind
            for (int i = 0; i < NUM_DIGITS; i++)
                shadow_digit[i] <= DIGIT_BLANK;
        end else begin
            frame_valid_r <= frame_done;

            if (frame_done) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    digits_r[4*i +: 4] <= shadow_digit[i];
                digit_err_r <= shadow_err;
            end

            if (capture) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_q[i]) begin
                        shadow_digit[i] <= dec.digit;
                        shadow_err[i]   <= dec.err;
                    end
                end
            end

            if (capture)
                seen <= (frame_done ? '0 : seen) | sel_q;
            else if (frame_done || timeout)
                seen <= '0;

            if (capture || timeout)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    assign bus.digits_out      = digits_r;
    assign bus.digit_err_out   = digit_err_r;
    assign bus.frame_valid_out = frame_valid_r;
    assign bus.scan_err_out    = scan_err_r;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: scans, short dwells, bad patterns,
// illegal selects, timeout and mid-frame reset, against hand-computed frames.
module tb_seg7_scan_capture;

    localparam int ND  = 6;
    localparam int SC  = 4;
    localparam int TO  = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   fv_cnt = 0;
    int   se_cnt = 0;

    seg7_scan_capture_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_capture #(
        .NUM_DIGITS     (ND),
        .STABLE_CYCLES  (SC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_valid_out) fv_cnt++;
            if (bus.scan_err_out)    se_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    task automatic show(input logic [ND-1:0] sel, input logic [6:0] seg, input int n);
        bus.dig_sel_in = sel;
        bus.seg_in     = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic show_digit(input int i, input logic [6:0] seg, input int n);
        logic [ND-1:0] one;
        one = 1;
        show(one << i, seg, n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        show('0, 7'h00, 3);
        rst_n = 1'b1;
    endtask

    int d_a[ND] = '{1, 2, 3, 4, 5, 9};
    int d_b[ND] = '{7, 0, 8, 6, 1, 2};
    int d_c[ND] = '{8, 9, 0, 1, 2, 3};
    int d_d[ND] = '{6, 5, 4, 3, 2, 1};

    initial begin
        int fv0, se0, n;
        bus.seg_in     = '0;
        bus.dig_sel_in = '0;

        // Reset values, then idle bus until the inter-capture timeout.
        show('0, 7'h00, 3);
        check("rst_digits", 32'(bus.digits_out), 32'hFFFFFF);
        check("rst_err",    32'(bus.digit_err_out), 32'h0);
        check("rst_fv",     32'(bus.frame_valid_out), 32'h0);
        check("rst_se",     32'(bus.scan_err_out), 32'h0);
        rst_n = 1'b1;
        n = 0;
        for (int k = 1; k <= TO + 20; k++) begin
            @(negedge clk);
            if (bus.scan_err_out) begin
                n = k;
                break;
            end
        end
        check("timeout_cycle", 32'(n), 32'(TO));
        check("idle_no_frame", 32'(fv_cnt), 32'h0);

        // Full scan 1,2,3,4,5,9.
        do_reset();
        fv0 = fv_cnt; se0 = se_cnt;
        for (int i = 0; i < ND - 1; i++) show_digit(i, enc(d_a[i]), 8);
        check("scan_mid_hold", 32'(bus.digits_out), 32'hFFFFFF);
        show_digit(ND - 1, enc(d_a[ND-1]), 8);
        show('0, 7'h00, 10);
        check("scan_fv",     32'(fv_cnt - fv0), 32'd1);
        check("scan_digits", 32'(bus.digits_out), 32'h954321);
        check("scan_err",    32'(bus.digit_err_out), 32'h0);
        check("scan_no_se",  32'(se_cnt - se0), 32'd0);

        // Short dwell on digit 3, then a full re-scan of digit 3.
        do_reset();
        fv0 = fv_cnt;
        for (int i = 0; i < ND; i++) show_digit(i, enc(d_b[i]), (i == 3) ? SC - 1 : 8);
        show('0, 7'h00, 10);
        check("short_no_fv",  32'(fv_cnt - fv0), 32'd0);
        check("short_digits", 32'(bus.digits_out), 32'hFFFFFF);
        show_digit(3, enc(d_b[3]), 8);
        show('0, 7'h00, 10);
        check("short_fv",     32'(fv_cnt - fv0), 32'd1);
        check("short_frame",  32'(bus.digits_out), 32'h216807);

        // Unrecognised 0x49 on digit 2 and blank 0x00 on digit 5.
        do_reset();
        fv0 = fv_cnt;
        show_digit(0, enc(3), 8);
        show_digit(1, enc(3), 8);
        show_digit(2, 7'h49, 8);
        show_digit(3, enc(5), 8);
        show_digit(4, enc(6), 8);
        show_digit(5, 7'h00, 8);
        show('0, 7'h00, 10);
        check("inv_fv",     32'(fv_cnt - fv0), 32'd1);
        check("inv_digits", 32'(bus.digits_out), 32'hF65E33);
        check("inv_err",    32'(bus.digit_err_out), 32'h04);

        // Multi-hot select: one error, no capture; blank gaps do not disturb a frame.
        do_reset();
        show('0, 7'h00, 10);
        se0 = se_cnt;
        show(6'b000011, enc(1), 10);
        show('0, 7'h00, 4);
        check("multi_se", 32'(se_cnt - se0), 32'd1);
        fv0 = fv_cnt; se0 = se_cnt;
        for (int i = 2; i < ND; i++) begin
            show_digit(i, enc(d_c[i]), 8);
            show('0, 7'h00, 3);
        end
        check("multi_no_capture", 32'(fv_cnt - fv0), 32'd0);
        for (int i = 0; i < 2; i++) begin
            show_digit(i, enc(d_c[i]), 8);
            show('0, 7'h00, 3);
        end
        show('0, 7'h00, 6);
        check("gap_fv",     32'(fv_cnt - fv0), 32'd1);
        check("gap_digits", 32'(bus.digits_out), 32'h321098);
        check("gap_no_se",  32'(se_cnt - se0), 32'd0);

        // Reset pulse after 3 of 6 digits discards the partial frame.
        do_reset();
        for (int i = 0; i < ND; i++) show_digit(i, enc(d_a[i]), 8);
        show('0, 7'h00, 10);
        check("pre_rst_digits", 32'(bus.digits_out), 32'h954321);
        for (int i = 0; i < 3; i++) show_digit(i, enc(7), 8);
        rst_n = 1'b0;
        show('0, 7'h00, 2);
        check("mid_rst_digits", 32'(bus.digits_out), 32'hFFFFFF);
        check("mid_rst_err",    32'(bus.digit_err_out), 32'h0);
        rst_n = 1'b1;
        fv0 = fv_cnt;
        for (int k = 0; k < ND; k++) show_digit((k + 3) % ND, enc(d_d[(k + 3) % ND]), 8);
        show('0, 7'h00, 10);
        check("post_rst_fv",     32'(fv_cnt - fv0), 32'd1);
        check("post_rst_digits", 32'(bus.digits_out), 32'h123456);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
